ex_stage_mc: RTL and testbench



---
 rtl/ex_pkg.sv | 40 ++++
 rtl/ex_divider.sv | 93 +++++++++
 rtl/ex_stage_mc.sv | 120 ++++++++++++
 tb/tb_ex_stage_mc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the multi-cycle execute stage
package ex_pkg;
    localparam int W_STATUS = 4;
    localparam int CL_ADDSUB = 0;
    localparam int CL_MUL    = 1;
    localparam int CL_DIV    = 2;
    localparam int CL_SHIFT  = 3;
    localparam int CL_LOGIC  = 4;
    localparam int CL_JUMP   = 5;
    localparam int CL_NOP    = 6;
    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MUL_LO = 3'd0;
    localparam logic [2:0] OP_SLL    = 3'd0;
    localparam logic [2:0] OP_SRL    = 3'd1;
    localparam logic [2:0] OP_SRA    = 3'd2;
    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NOT    = 3'd3;
    localparam logic [2:0] OP_DIVU   = 3'd0;
    localparam logic [2:0] OP_REMU   = 3'd1;
    localparam logic [2:0] OP_DIVS   = 3'd2;
    localparam logic [2:0] OP_REMS   = 3'd3;
    localparam logic [2:0] OP_JABS   = 3'd0;
    localparam logic [2:0] OP_JREL   = 3'd1;
    localparam logic [2:0] CC_AL = 3'd0;
    localparam logic [2:0] CC_Z  = 3'd1;
    localparam logic [2:0] CC_NZ = 3'd2;
    localparam logic [2:0] CC_S  = 3'd3;
    localparam logic [2:0] CC_NS = 3'd4;
    localparam logic [2:0] CC_C  = 3'd5;
    localparam logic [2:0] CC_NC = 3'd6;
    localparam logic [2:0] CC_V  = 3'd7;
    localparam int F_V = 0;
    localparam int F_C = 1;
    localparam int F_S = 2;
    localparam int F_Z = 3;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIN} div_state_e;
endpackage

// File: rtl/ex_divider.sv
// ex_divider: restoring divider on magnitudes, one step per cycle, sign fix-up in FIN
import ex_pkg::*;
module ex_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] dvd_i,
    input  logic [W-1:0] dvs_i,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         exc
);
    localparam int WC = $clog2(W);
    div_state_e state_q, state_d;
    logic [WC-1:0] cnt_q, cnt_d;
    logic [W-1:0] q_q, q_d, r_q, r_d, d_q, d_d, a_q, a_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, ovf_q, ovf_d;
    logic sa, sb;
    logic [W:0] shl, diff;
    always_comb begin
        sa      = is_signed & dvd_i[W-1];
        sb      = is_signed & dvs_i[W-1];
        shl     = {r_q, q_q[W-1]};
        diff    = shl - {1'b0, d_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        a_d     = a_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_BUSY;
                cnt_d   = WC'(W - 1);
                q_d     = sa ? -dvd_i : dvd_i;
                r_d     = '0;
                d_d     = sb ? -dvs_i : dvs_i;
                a_d     = dvd_i;
                qneg_d  = sa ^ sb;
                rneg_d  = sa;
                zero_d  = dvs_i == '0;
                ovf_d   = is_signed & (dvd_i == {1'b1, {(W-1){1'b0}}}) & (&dvs_i);
            end
            S_BUSY: begin
                q_d     = {q_q[W-2:0], ~diff[W]};
                r_d     = diff[W] ? shl[W-1:0] : diff[W-1:0];
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? S_FIN : S_BUSY;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            a_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            a_q     <= a_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end
    assign busy = state_q == S_BUSY;
    assign done = state_q == S_FIN;
    assign exc  = zero_q | ovf_q;
    // MIN / -1 already yields MIN and 0 from the magnitude path; only the flag is special
    assign quo  = zero_q ? '1 : qneg_q ? -q_q : q_q;
    assign rem  = zero_q ? a_q : rneg_q ? -r_q : r_q;
endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: multi-cycle execute stage with iterative divider, status flags and conditional jumps
import ex_pkg::*;
module ex_stage_mc #(
    parameter int W_WORD = 32,
    parameter int W_ADDR = 32,
    parameter int W_RD   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                v_i,
    output logic                stall_o,
    input  logic [6:0]          class_i,
    input  logic [2:0]          opc_i,
    input  logic [W_WORD-1:0]   src_i,
    input  logic [W_WORD-1:0]   dest_i,
    input  logic                wb_i,
    input  logic [W_RD-1:0]     rd_num_i,
    input  logic [2:0]          cc_i,
    input  logic [W_ADDR-1:0]   origaddr_i,
    output logic                branch_o,
    output logic [W_ADDR-1:0]   baddr_o,
    output logic                v_o,
    output logic                wb_o,
    output logic [W_RD-1:0]     rd_num_o,
    output logic [W_WORD-1:0]   rd_data_o,
    output logic [W_STATUS-1:0] status_o
);
    localparam int WS = $clog2(W_WORD);
    logic [6:0] cls;
    logic idle, stall, cond, taken, div_busy, div_done, div_exc, div_start, div_signed;
    logic as_c, as_v, sub, z, s, c, v;
    logic [W_WORD:0] sum, dif;
    logic [W_WORD-1:0] quo, rem, as_res, sh_res, sra_res, lg_res, mul_res, div_res, res;
    logic [WS-1:0] sh;
    logic [W_ADDR-1:0] tgt;
    logic [W_STATUS-1:0] fl;
    logic v_d, v_q, wb_d, wb_q;
    logic [W_RD-1:0] rd_num_d, rd_num_q;
    logic [W_WORD-1:0] rd_data_d, rd_data_q;
    logic [W_STATUS-1:0] status_d, status_q;
    ex_divider #(.W(W_WORD)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .is_signed (div_signed),
        .dvd_i     (dest_i),
        .dvs_i     (src_i),
        .busy      (div_busy),
        .done      (div_done),
        .quo       (quo),
        .rem       (rem),
        .exc       (div_exc)
    );
    always_comb begin
        cls        = (class_i != '0 && (class_i & (class_i - 7'd1)) == '0) ? class_i : 7'(1 << CL_NOP);
        idle       = ~div_busy & ~div_done;
        div_start  = v_i & cls[CL_DIV];
        div_signed = opc_i == OP_DIVS || opc_i == OP_REMS;
        stall      = div_busy | (idle & div_start);
        sum        = {1'b0, dest_i} + {1'b0, src_i};
        dif        = {1'b0, dest_i} - {1'b0, src_i};
        sub        = opc_i == OP_SUB;
        as_res     = sub ? dif[W_WORD-1:0] : sum[W_WORD-1:0];
        as_c       = sub ? dif[W_WORD] : sum[W_WORD];
        as_v       = (sub ? dest_i[W_WORD-1] ^ src_i[W_WORD-1] : ~(dest_i[W_WORD-1] ^ src_i[W_WORD-1]))
                     & (as_res[W_WORD-1] ^ dest_i[W_WORD-1]);
        sh         = src_i[WS-1:0];
        sra_res    = $signed(dest_i) >>> sh;
        sh_res     = opc_i == OP_SLL ? dest_i << sh : opc_i == OP_SRL ? dest_i >> sh :
                     opc_i == OP_SRA ? sra_res : '0;
        lg_res     = opc_i == OP_AND ? dest_i & src_i : opc_i == OP_OR ? dest_i | src_i :
                     opc_i == OP_XOR ? dest_i ^ src_i : opc_i == OP_NOT ? ~dest_i : '0;
        mul_res    = opc_i == OP_MUL_LO ? dest_i * src_i : '0;
        div_res    = (opc_i == OP_REMU || opc_i == OP_REMS) ? rem : quo;
        res        = cls[CL_ADDSUB] ? as_res : cls[CL_MUL] ? mul_res : cls[CL_DIV] ? div_res :
                     cls[CL_SHIFT] ? sh_res : cls[CL_LOGIC] ? lg_res : '0;
        z          = status_q[F_Z];
        s          = status_q[F_S];
        c          = status_q[F_C];
        v          = status_q[F_V];
        cond       = cc_i == CC_AL ? 1'b1 : cc_i == CC_Z ? z : cc_i == CC_NZ ? ~z : cc_i == CC_S ? s :
                     cc_i == CC_NS ? ~s : cc_i == CC_C ? c : cc_i == CC_NC ? ~c : v;
        taken      = v_i & cls[CL_JUMP] & idle & cond;
        tgt        = opc_i == OP_JABS ? W_ADDR'(src_i) : opc_i == OP_JREL ? origaddr_i + W_ADDR'(src_i) : '0;
        // the held div is re-presented during FIN; only the divider's done makes it valid
        v_d        = div_done | (v_i & ~stall & ~cls[CL_DIV]);
        wb_d       = v_d & wb_i & ~cls[CL_JUMP] & ~cls[CL_NOP];
        rd_num_d   = v_d ? rd_num_i : rd_num_q;
        rd_data_d  = v_d ? res : rd_data_q;
        fl         = '0;
        fl[F_Z]    = res == '0;
        fl[F_S]    = res[W_WORD-1];
        fl[F_C]    = cls[CL_ADDSUB] & as_c;
        fl[F_V]    = cls[CL_ADDSUB] ? as_v : cls[CL_DIV] & div_exc;
        status_d   = v_d & (cls[CL_ADDSUB] | cls[CL_LOGIC] | cls[CL_SHIFT] | cls[CL_DIV]) ? fl : status_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= 1'b0;
            wb_q      <= 1'b0;
            rd_num_q  <= '0;
            rd_data_q <= '0;
            status_q  <= '0;
        end else begin
            v_q       <= v_d;
            wb_q      <= wb_d;
            rd_num_q  <= rd_num_d;
            rd_data_q <= rd_data_d;
            status_q  <= status_d;
        end
    end
    assign stall_o   = rst_n & stall;
    assign branch_o  = rst_n & taken;
    assign baddr_o   = branch_o ? tgt : '0;
    assign v_o       = v_q;
    assign wb_o      = wb_q;
    assign rd_num_o  = rd_num_q;
    assign rd_data_o = rd_data_q;
    assign status_o  = status_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: directed plus randomized checks of ex_stage_mc against an arithmetic reference model
module tb_ex_stage_mc;
    localparam int W  = 8;
    localparam int WA = 16;
    localparam int WR = 5;
    logic clk = 0, rst_n = 1, v_i = 0, wb_i = 0;
    logic stall_o, branch_o, v_o, wb_o;
    logic [6:0] class_i = '0;
    logic [2:0] opc_i = '0, cc_i = '0;
    logic [W-1:0] src_i = '0, dest_i = '0, rd_data_o;
    logic [WR-1:0] rd_num_i = '0, rd_num_o;
    logic [WA-1:0] origaddr_i = '0, baddr_o;
    logic [3:0] status_o;
    logic [3:0] exp_status = '0;
    int checks = 0, errors = 0;

    ex_stage_mc #(.W_WORD(W), .W_ADDR(WA), .W_RD(WR)) dut (
        .clk(clk), .rst_n(rst_n), .v_i(v_i), .stall_o(stall_o), .class_i(class_i), .opc_i(opc_i),
        .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .rd_num_i(rd_num_i), .cc_i(cc_i),
        .origaddr_i(origaddr_i), .branch_o(branch_o), .baddr_o(baddr_o), .v_o(v_o), .wb_o(wb_o),
        .rd_num_o(rd_num_o), .rd_data_o(rd_data_o), .status_o(status_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int x);
        return x > 127 ? x - 256 : x;
    endfunction

    // class k: 0 addsub 1 mul 2 div 3 shift 4 logic 5 jump 6 nop
    function automatic void model(input int k, input int opc, input int s, input int d,
                                  output int res, output logic [3:0] fl, output bit upd);
        int ss, sd, q, r;
        bit c, v;
        ss = sx(s); sd = sx(d); c = 0; v = 0; res = 0;
        upd = (k == 0 || k == 2 || k == 3 || k == 4);
        case (k)
            0: if (opc == 1) begin
                   res = (d - s) & 255; c = d < s; v = (sd - ss) < -128 || (sd - ss) > 127;
               end else begin
                   res = (d + s) & 255; c = (d + s) > 255; v = (sd + ss) < -128 || (sd + ss) > 127;
               end
            1: res = (d * s) & 255;
            2: begin
                if (s == 0) begin q = 255; r = d; v = 1; end
                else if (opc >= 2 && sd == -128 && ss == -1) begin q = 128; r = 0; v = 1; end
                else if (opc >= 2) begin q = (sd / ss) & 255; r = (sd % ss) & 255; end
                else begin q = d / s; r = d % s; end
                res = (opc % 2) ? r : q;
            end
            3: res = opc == 0 ? (d << (s % 8)) & 255 : opc == 1 ? d >> (s % 8) : (sd >>> (s % 8)) & 255;
            4: res = opc == 0 ? d & s : opc == 1 ? d | s : opc == 2 ? d ^ s : (~d) & 255;
            default: res = 0;
        endcase
        fl = {res == 0, res > 127, c, v};
    endfunction

    function automatic bit cond_ok(input int cc, input logic [3:0] st);
        case (cc)
            0: return 1;
            1: return st[3];
            2: return !st[3];
            3: return st[2];
            4: return !st[2];
            5: return st[1];
            6: return !st[1];
            default: return st[0];
        endcase
    endfunction

    task automatic drive(input int k, input int opc, input int s, input int d, input bit wb,
                         input int rd, input int cc, input int org);
        v_i = 1; class_i = 7'(1 << k); opc_i = 3'(opc); src_i = 8'(s); dest_i = 8'(d);
        wb_i = wb; rd_num_i = 5'(rd); cc_i = 3'(cc); origaddr_i = 16'(org);
    endtask

    task automatic exec(input int k, input int opc, input int s, input int d, input bit wb,
                        input int rd, input int cc, input int org);
        int res, n;
        logic [3:0] fl;
        bit upd, tk;
        drive(k, opc, s, d, wb, rd, cc, org);
        #1;
        if (k == 2) begin
            n = 0;
            while (stall_o && n < 40) begin
                if (n > 0) chk("div_bubble_v", v_o, 0);
                @(posedge clk); #1; n++;
            end
            chk("div_stall_len", n, 9);
            chk("fin_bubble_v", v_o, 0);
            chk("fin_status_hold", status_o, exp_status);
        end else begin
            chk("stall_low", stall_o, 0);
            if (k == 5) begin
                tk = cond_ok(cc, exp_status);
                chk("branch", branch_o, tk);
                if (tk) chk("baddr", baddr_o, opc == 0 ? s : (org + s) & 16'hFFFF);
            end
        end
        @(posedge clk); #1;
        model(k, opc, s, d, res, fl, upd);
        chk("v_o", v_o, 1);
        chk("wb_o", wb_o, wb && k < 5);
        if (k < 5) begin
            chk("rd_num", rd_num_o, rd);
            chk("rd_data", rd_data_o, res);
        end
        if (upd) exp_status = fl;
        chk("status", status_o, exp_status);
    endtask

    initial begin
        int k, opc, s, d;
        #2 rst_n = 0;
        #1;
        chk("rst_v", v_o, 0);
        chk("rst_wb", wb_o, 0);
        chk("rst_rd", rd_num_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_status", status_o, 0);
        chk("rst_branch", branch_o, 0);
        chk("rst_baddr", baddr_o, 0);
        chk("rst_stall", stall_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        exec(0, 0, 8'h01, 8'h7F, 1, 3, 0, 0);
        chk("add_flags", status_o, 4'b0101);
        exec(0, 1, 5, 5, 1, 4, 0, 0);
        exec(5, 0, 8'h40, 0, 1, 0, 1, 16'h1234);
        exec(5, 0, 8'h40, 0, 1, 0, 2, 16'h1234);
        exec(5, 1, 8'hF0, 0, 0, 0, 0, 16'hFFF8);
        exec(2, 0, 7, 200, 1, 7, 0, 0);
        chk("divu_res", rd_data_o, 28);
        exec(2, 2, 2, 8'hF9, 1, 8, 0, 0);
        chk("divs_res", rd_data_o, 8'hFD);
        exec(2, 3, 2, 8'hF9, 1, 9, 0, 0);
        chk("rems_res", rd_data_o, 8'hFF);
        exec(2, 2, 8'hFF, 8'h80, 1, 10, 0, 0);
        chk("divs_ovf", {rd_data_o, status_o[0]}, {8'h80, 1'b1});
        exec(2, 0, 0, 9, 1, 11, 0, 0);
        chk("divu_zero", {rd_data_o, status_o[0]}, {8'hFF, 1'b1});
        exec(2, 1, 0, 9, 1, 12, 0, 0);
        exec(2, 0, 3, 100, 1, 13, 0, 0);
        exec(2, 1, 3, 100, 1, 14, 0, 0);
        exec(0, 0, 1, 2, 1, 15, 0, 0);
        drive(6, 0, 1, 1, 1, 16, 0, 0);
        class_i = 7'b0000101;
        #1 chk("nonhot_stall", stall_o, 0);
        @(posedge clk); #1;
        chk("nonhot_v", v_o, 1);
        chk("nonhot_wb", wb_o, 0);
        chk("nonhot_status", status_o, exp_status);
        drive(2, 0, 7, 200, 1, 17, 0, 0);
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_stall", stall_o, 0);
        chk("mid_rst_out", {v_o, wb_o, rd_num_o, rd_data_o, status_o}, 0);
        v_i = 0;
        exp_status = '0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_v", v_o, 0);
        exec(0, 0, 8'h10, 8'h22, 1, 18, 0, 0);
        chk("post_rst_add", rd_data_o, 8'h32);
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 6);
            opc = k == 0 ? $urandom_range(0, 1) : k == 2 ? $urandom_range(0, 3) : k == 3 ? $urandom_range(0, 2) :
                  k == 4 ? $urandom_range(0, 3) : k == 5 ? $urandom_range(0, 1) : 0;
            s = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 255);
            d = $urandom_range(0, 7) == 0 ? 128 : $urandom_range(0, 255);
            exec(k, opc, s, d, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 7),
                 $urandom_range(0, 65535));
        end
        v_i = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
